// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
//  Shared definitions for the elastic immediate generator.
//  - imm_fmt_e    : immediate format select carried alongside instr[31:7]
//  - SKID_DEPTH   : the only buffer depth the skid buffer supports
//  - imm_decode() : turns instr[31:7] plus a format into a 64-bit immediate.
//                   Callers with XLEN=32 keep the low 32 bits, which are
//                   already correct for every format at that width.
// -----------------------------------------------------------------------------
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_I   = 3'd0,
      FMT_S   = 3'd1,
      FMT_B   = 3'd2,
      FMT_U   = 3'd3,
      FMT_J   = 3'd4,
      FMT_Z   = 3'd5,
      FMT_SH  = 3'd6,
      FMT_RSV = 3'd7
   } imm_fmt_e;

   localparam int SKID_DEPTH = 2;

   function automatic logic [63:0] imm_decode(
      input logic [24:0] imm_in,
      input imm_fmt_e    fmt,
      input int          xlen
   );
      logic [31:0] instr;
      logic        sgn;
      logic [63:0] imm;
      instr = {imm_in, 7'b0};
      sgn   = instr[31];
      imm   = '0;
      case (fmt)
         FMT_I:   imm = {{52{sgn}}, instr[31:20]};
         FMT_S:   imm = {{52{sgn}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{52{sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {{32{sgn}}, instr[31:12], 12'h000};
         FMT_J:   imm = {{44{sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_Z:   imm = {59'b0, instr[19:15]};
         // RV64 shifts take a 6-bit shamt; RV32 only 5 bits
         FMT_SH:  imm = (xlen == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// -----------------------------------------------------------------------------
// imm_skid_buf
//  Generic 2-entry valid/ready buffer. in_ready is a register derived from the
//  next occupancy, so there is no combinational path from out_ready to
//  in_ready. Entries leave in strict FIFO order.
// Ports
//  clk, rst_n            clock, async active-low reset
//  flush                 drop all entries at the next edge (same-cycle push lost)
//  in_valid/in_ready     upstream handshake, in_data W bits
//  out_valid/out_ready   downstream handshake, out_data W bits (head entry)
// -----------------------------------------------------------------------------
module imm_skid_buf #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         r_in_ready;

   logic         w_push;
   logic         w_pop;
   logic [1:0]   w_count_nxt;

   // A full buffer never has r_in_ready set, so pushes while full are ignored.
   assign w_push = in_valid & r_in_ready & ~flush;
   assign w_pop  = (r_count != 2'd0) & out_ready;

   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = 2'd0;
      end else begin
         w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         // Held low through reset; rises on the first edge after release.
         r_in_ready <= 1'b0;
      end else begin
         if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
         end else begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= in_data;
               r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
         end
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt != 2'd2);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//  Elastic immediate generator for the decode stage. instr[31:7] and a format
//  select are decoded combinationally, then the {fmt_err, imm} pair is queued
//  in a 2-entry skid buffer; the head entry is presented one cycle after
//  acceptance into an empty buffer.
// Parameters
//  XLEN   32 or 64, immediate width
//  DEPTH  must be 2
// Ports
//  clk, rst_n            clock, async active-low reset
//  flush                 drop all buffered entries at the next edge
//  in_valid/in_ready     request handshake; imm_in = instr[31:7], fmt = imm_fmt_e
//  out_valid/out_ready   response handshake; imm_out, fmt_err of head entry
// -----------------------------------------------------------------------------
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [24:0]     imm_in,
   input  logic [2:0]      fmt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_out,
   output logic            fmt_err
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end
   if (DEPTH != SKID_DEPTH) begin : g_bad_depth
      $error("imm_gen_pipe: DEPTH must be 2");
   end

   imm_fmt_e        w_fmt;
   logic [63:0]     w_imm_full;
   logic [XLEN-1:0] w_imm;
   logic            w_fmt_err;
   logic [XLEN:0]   w_buf_in;
   logic [XLEN:0]   w_buf_out;
   logic            w_unused_hi;

   assign w_fmt      = imm_fmt_e'(fmt);
   assign w_imm_full = imm_decode(imm_in, w_fmt, XLEN);
   assign w_imm      = w_imm_full[XLEN-1:0];
   assign w_fmt_err  = (w_fmt == FMT_RSV);
   // Upper decode bits are dropped when XLEN=32.
   assign w_unused_hi = &{1'b0, w_imm_full};

   assign w_buf_in = {w_fmt_err, w_imm};

   imm_skid_buf #(
      .W (XLEN + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_buf_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (w_buf_out)
   );

   assign imm_out = w_buf_out[XLEN-1:0];
   assign fmt_err = w_buf_out[XLEN];

endmodule
